// File: rtl/fifo_ctrl.sv
// ----------------------------------------------------------------------------
// fifo_ctrl
//   Show-ahead FIFO controller wrapped around an external simple dual-port RAM
//   whose read port is registered. The RAM output register is the output stage,
//   so the controller holds up to DEPTH words in RAM plus one word presented
//   on rd_data_o. That makes DEPTH+1 words in total.
//
// Parameters
//   DWIDTH         data word width
//   AWIDTH         RAM address width (RAM depth is 2**AWIDTH)
//
// Ports
//   clk_i          clock, all state on rising edge
//   rst_ni         asynchronous active-low reset
//   wr_valid_i     producer offers wr_data_i
//   wr_data_i      producer word
//   wr_ready_o     controller can take a word this cycle
//   rd_valid_o     rd_data_o holds the head word
//   rd_data_o      head word, taken straight from the RAM read register
//   rd_ready_i     consumer takes the head word
//   usedw_o        words held (RAM occupancy plus the presented word)
//   ram_wr_en_o    RAM write enable
//   ram_wr_addr_o  RAM write address
//   ram_wr_data_o  RAM write data
//   ram_rd_en_o    RAM read enable
//   ram_rd_addr_o  RAM read address
//   ram_rd_data_i  RAM registered read data
// ----------------------------------------------------------------------------
module fifo_ctrl #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_valid_i,
  input  logic [DWIDTH-1:0] wr_data_i,
  output logic              wr_ready_o,
  output logic              rd_valid_o,
  output logic [DWIDTH-1:0] rd_data_o,
  input  logic              rd_ready_i,
  output logic [AWIDTH:0]   usedw_o,
  output logic              ram_wr_en_o,
  output logic [AWIDTH-1:0] ram_wr_addr_o,
  output logic [DWIDTH-1:0] ram_wr_data_o,
  output logic              ram_rd_en_o,
  output logic [AWIDTH-1:0] ram_rd_addr_o,
  input  logic [DWIDTH-1:0] ram_rd_data_i
);

  localparam int DEPTH = 2 ** AWIDTH;
  localparam logic [AWIDTH:0] CNT_FULL = (AWIDTH + 1)'(DEPTH);

  logic [AWIDTH-1:0] r_wptr;
  logic [AWIDTH-1:0] r_rptr;
  logic [AWIDTH:0]   r_cnt;
  logic              r_rd_valid;

  logic w_wr;
  logic w_pop;
  logic w_out_free;

  // The output stage can take a new word when it is empty or being consumed.
  assign w_out_free = !r_rd_valid || rd_ready_i;

  // Write acceptance only looks at registered occupancy. The write is also
  // gated by rst_ni so that no RAM write leaks out while reset is held.
  assign wr_ready_o = (r_cnt != CNT_FULL);
  assign w_wr       = wr_valid_i && wr_ready_o && rst_ni;
  assign w_pop      = (r_cnt != '0) && w_out_free;

  assign ram_wr_en_o   = w_wr;
  assign ram_wr_addr_o = r_wptr;
  assign ram_wr_data_o = wr_data_i;

  assign ram_rd_en_o   = w_pop;
  assign ram_rd_addr_o = r_rptr;

  assign rd_valid_o = r_rd_valid;
  assign rd_data_o  = ram_rd_data_i;
  assign usedw_o    = r_cnt + {{AWIDTH{1'b0}}, r_rd_valid};

  // The write pointer only moves on accepted writes. The read pointer only
  // moves on pops, so reads only reach occupied slots and writes only reach
  // free slots.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + AWIDTH'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AWIDTH'(1);
      end
    end
  end

  // RAM occupancy. A simultaneous write and pop leaves it unchanged.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else begin
      case ({w_wr, w_pop})
        2'b10:   r_cnt <= r_cnt + (AWIDTH + 1)'(1);
        2'b01:   r_cnt <= r_cnt - (AWIDTH + 1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // A pop loads the RAM output register one cycle later, so the valid flag
  // tracks the pop whenever the output stage is free. Otherwise it holds.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_valid <= 1'b0;
    end else if (w_out_free) begin
      r_rd_valid <= w_pop;
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// ----------------------------------------------------------------------------
// tb_fifo_ctrl
//   Directed and scoreboard-driven test of fifo_ctrl (DWIDTH=8, AWIDTH=4)
//   with a behavioural registered-read RAM attached to its RAM port.
// ----------------------------------------------------------------------------
module tb_fifo_ctrl;

  logic       clk;
  logic       rstN;
  logic       wrValid;
  logic [7:0] wrData;
  logic       wrReady;
  logic       rdValid;
  logic [7:0] rdData;
  logic       rdReady;
  logic [4:0] usedw;
  logic       ramWrEn;
  logic [3:0] ramWrAddr;
  logic [7:0] ramWrData;
  logic       ramRdEn;
  logic [3:0] ramRdAddr;
  logic [7:0] ramRdData;

  logic [7:0] mem [16];

  int total;
  int bad;

  fifo_ctrl #(.DWIDTH(8), .AWIDTH(4)) dut (
    .clk_i        (clk),
    .rst_ni       (rstN),
    .wr_valid_i   (wrValid),
    .wr_data_i    (wrData),
    .wr_ready_o   (wrReady),
    .rd_valid_o   (rdValid),
    .rd_data_o    (rdData),
    .rd_ready_i   (rdReady),
    .usedw_o      (usedw),
    .ram_wr_en_o  (ramWrEn),
    .ram_wr_addr_o(ramWrAddr),
    .ram_wr_data_o(ramWrData),
    .ram_rd_en_o  (ramRdEn),
    .ram_rd_addr_o(ramRdAddr),
    .ram_rd_data_i(ramRdData)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read RAM. Read data is held while the read enable is low.
  always_ff @(posedge clk) begin
    if (ramWrEn) begin
      mem[ramWrAddr] <= ramWrData;
    end
    if (ramRdEn) begin
      ramRdData <= mem[ramRdAddr];
    end
  end

  // Drive the inputs for the current cycle, then let the combinational
  // outputs settle before any check is made.
  task automatic applyStimulus(input logic wv, input logic [7:0] wd, input logic rr);
    wrValid = wv;
    wrData  = wd;
    rdReady = rr;
    #1;
  endtask

  // Move to the next cycle. Outputs are sampled 1 unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] sb [$];
    logic       wv;
    logic       rr;
    logic [7:0] wd;
    logic       prevStall;
    int         guard;

    total     = 0;
    bad       = 0;
    rstN      = 1'b0;
    wrValid   = 1'b0;
    wrData    = '0;
    rdReady   = 1'b0;
    prevStall = 1'b0;

    // Reset state, with a write offered so the write enable gate is exercised.
    applyStimulus(1'b1, 8'h11, 1'b1);
    tick();
    checkOutput("rstWrReady", wrReady, 1);
    checkOutput("rstUsedw", usedw, 0);
    checkOutput("rstRamWrEn", ramWrEn, 0);
    checkOutput("rstRamRdEn", ramRdEn, 0);
    checkOutput("rstRdValid", rdValid, 0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    rstN = 1'b1;
    tick();

    // Single word 0xA5 with two-cycle latency.
    applyStimulus(1'b1, 8'hA5, 1'b1);
    checkOutput("singleWrEn", ramWrEn, 1);
    checkOutput("singleWrAddr", ramWrAddr, 0);
    checkOutput("singleWrData", ramWrData, 8'hA5);
    checkOutput("singleUsedw0", usedw, 0);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("singleRvN1", rdValid, 0);
    checkOutput("singleRdEn", ramRdEn, 1);
    checkOutput("singleRdAddr", ramRdAddr, 0);
    checkOutput("singleUsedwN1", usedw, 1);
    tick();
    checkOutput("singleRvN2", rdValid, 1);
    checkOutput("singleData", rdData, 8'hA5);
    checkOutput("singleUsedwN2", usedw, 1);
    tick();
    checkOutput("singleRvN3", rdValid, 0);
    checkOutput("singleUsedwN3", usedw, 0);

    // Fill with the consumer stalled. 17 words fit, the 18th is dropped.
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b0);
      checkOutput($sformatf("fillReady%0d", i), wrReady, 1);
      tick();
    end
    applyStimulus(1'b1, 8'd17, 1'b0);
    checkOutput("fullWrReady", wrReady, 0);
    checkOutput("fullWrEn", ramWrEn, 0);
    checkOutput("fullUsedw", usedw, 17);
    checkOutput("fullRv", rdValid, 1);
    checkOutput("fullHead", rdData, 0);
    tick();
    checkOutput("fullUsedwAfterDrop", usedw, 17);

    // Drain from full. The first cycle also attempts a write, which must be
    // rejected while the pop still happens.
    for (int i = 0; i < 17; i++) begin
      if (i == 0) begin
        applyStimulus(1'b1, 8'hEE, 1'b1);
        checkOutput("fullPopWrEn", ramWrEn, 0);
        checkOutput("fullPopRdEn", ramRdEn, 1);
      end else begin
        applyStimulus(1'b0, 8'h00, 1'b1);
      end
      checkOutput($sformatf("drainRv%0d", i), rdValid, 1);
      checkOutput($sformatf("drainData%0d", i), rdData, i);
      tick();
    end
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("drainEndRv", rdValid, 0);
    checkOutput("drainEndUsedw", usedw, 0);

    // Streaming: one write and one read per cycle for 40 cycles.
    for (int c = 0; c < 40; c++) begin
      applyStimulus(1'b1, 8'(8'h80 + c), 1'b1);
      if (c >= 2) begin
        checkOutput($sformatf("streamRv%0d", c), rdValid, 1);
        checkOutput($sformatf("streamData%0d", c), rdData, 8'h80 + c - 2);
        checkOutput($sformatf("streamUsedw%0d", c), usedw, 2);
      end
      tick();
    end
    for (int c = 40; c < 42; c++) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput($sformatf("streamTailRv%0d", c), rdValid, 1);
      checkOutput($sformatf("streamTailData%0d", c), rdData, 8'h80 + c - 2);
      tick();
    end
    checkOutput("streamEndRv", rdValid, 0);

    // Asynchronous reset mid-stream with five words held.
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b0);
      tick();
    end
    applyStimulus(1'b1, 8'h99, 1'b0);
    checkOutput("preRstUsedw", usedw, 5);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("midRstWrReady", wrReady, 1);
    checkOutput("midRstUsedw", usedw, 0);
    checkOutput("midRstWrEn", ramWrEn, 0);
    checkOutput("midRstRdEn", ramRdEn, 0);
    checkOutput("midRstRv", rdValid, 0);
    tick();
    rstN = 1'b1;
    applyStimulus(1'b1, 8'h3C, 1'b1);
    checkOutput("postRstWrEn", ramWrEn, 1);
    checkOutput("postRstWrAddr", ramWrAddr, 0);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("postRstRvN1", rdValid, 0);
    tick();
    checkOutput("postRstRv", rdValid, 1);
    checkOutput("postRstData", rdData, 8'h3C);
    tick();
    checkOutput("postRstEmpty", usedw, 0);

    // Random traffic against a scoreboard queue.
    for (int c = 0; c < 400; c++) begin
      wv = ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 1) != 0);
      wd = 8'($urandom_range(0, 255));
      applyStimulus(wv, wd, rr);
      checkOutput("rndUsedw", usedw, sb.size());
      if (prevStall) begin
        checkOutput("rndStallRv", rdValid, 1);
      end
      if (rdValid) begin
        checkOutput("rndSbNonEmpty", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          checkOutput("rndData", rdData, sb[0]);
        end
      end
      prevStall = rdValid && !rr;
      if (rdValid && rr && sb.size() > 0) begin
        void'(sb.pop_front());
      end
      if (wv && wrReady) begin
        sb.push_back(wd);
      end
      tick();
    end

    // Drain the random traffic under a cycle budget.
    guard = 0;
    while ((sb.size() > 0 || rdValid) && guard < 60) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("rndDrainUsedw", usedw, sb.size());
      if (rdValid) begin
        checkOutput("rndDrainSbNonEmpty", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          checkOutput("rndDrainData", rdData, sb[0]);
          void'(sb.pop_front());
        end
      end
      tick();
      guard++;
    end
    checkOutput("rndDrainBudget", guard < 60, 1);
    checkOutput("rndDrainSbEmpty", sb.size(), 0);
    checkOutput("rndDrainUsedwEnd", usedw, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
